prog_mem_sync: RTL

- Parametrised, writable successor to the fixed combinational program ROM: a synchronous instruction memory with a registered fetch port.
- Adds a streaming program-load port and a post-reset clear sequence.
- Sits between the PC/fetch stage and an external program loader (bench or boot controller).
- Replaces hard-coded program contents with contents loaded at run time.

---
 rtl/prog_mem_sync.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/prog_mem_sync.sv
// ============================================================================
// prog_mem_sync : writable synchronous program memory with registered fetch,
//                 streaming load port and post-reset clear sequence.
// Optional feature macro: PROG_MEM_PARITY_EN (per-word even parity).
// Revision: 1.0
// ============================================================================
`default_nettype none

module prog_mem_sync #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              out_perr,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err,
  output logic              busy
);

`ifdef PROG_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  logic [MEM_W-1:0] mem_q [DEPTH];

  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] clr_ptr_q,   clr_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [DATA_W-1:0] out_q,       out_d;
  logic              out_valid_q, out_valid_d;
  logic              out_perr_q,  out_perr_d;
  logic              ld_ready_q,  ld_ready_d;
  logic              ld_done_q,   ld_done_d;
  logic              ld_err_q,    ld_err_d;
  logic              busy_q,      busy_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;
  logic              fetch_in_range;
  logic              base_in_range;

  assign fetch_in_range = {1'b0, address} < DEPTH_W;
  assign base_in_range  = {1'b0, ld_base} < DEPTH_W;
  assign rd_word        = mem_q[address];

`ifdef PROG_MEM_PARITY_EN
  // Stored bit makes the XOR over the whole word zero (even parity).
  assign wr_word = {^wr_data, wr_data};
`else
  assign wr_word = wr_data;
`endif

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    out_perr_d  = 1'b0;
    ld_done_d   = 1'b0;
    ld_err_d    = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = clr_ptr_q;
    wr_data     = NOP_WORD;

    case (state_q)
      ST_CLEAR: begin
        wr_en = 1'b1;
        if (clr_ptr_q == LAST_IDX) begin
          clr_ptr_d = '0;
          state_d   = ST_IDLE;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end

      ST_IDLE: begin
        // A fetch in the same cycle as ld_start sees the pre-load contents.
        if (fetch_en) begin
          out_valid_d = 1'b1;
          if (fetch_in_range) begin
            out_d = rd_word[DATA_W-1:0];
`ifdef PROG_MEM_PARITY_EN
            out_perr_d = ^rd_word;
`endif
          end else begin
            out_d = NOP_WORD;
          end
        end
        if (ld_start) begin
          if (base_in_range) begin
            state_d  = ST_LOAD;
            wr_ptr_d = ld_base;
          end else begin
            ld_err_d = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (ld_valid && ld_ready_q) begin
          wr_en    = 1'b1;
          wr_addr  = wr_ptr_q;
          wr_data  = ld_data;
          wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
          if (ld_last) begin
            state_d   = ST_IDLE;
            ld_done_d = 1'b1;
          end
        end
      end

      default: state_d = ST_CLEAR;
    endcase

    ld_ready_d = (state_d == ST_LOAD);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_ptr_q   <= '0;
      wr_ptr_q    <= '0;
      out_q       <= NOP_WORD;
      out_valid_q <= 1'b0;
      out_perr_q  <= 1'b0;
      ld_ready_q  <= 1'b0;
      ld_done_q   <= 1'b0;
      ld_err_q    <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_perr_q  <= out_perr_d;
      ld_ready_q  <= ld_ready_d;
      ld_done_q   <= ld_done_d;
      ld_err_q    <= ld_err_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_word;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign ld_ready  = ld_ready_q;
  assign ld_done   = ld_done_q;
  assign ld_err    = ld_err_q;
  assign busy      = busy_q;
`ifdef PROG_MEM_PARITY_EN
  assign out_perr  = out_perr_q;
`else
  assign out_perr  = 1'b0;
`endif

endmodule

`default_nettype wire
